// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter slice.
//   mode_e   : counting mode at a range end (wrap around or saturate)
//   DIR_UP   : value of the 'up' input that selects incrementing
//   DIR_DOWN : value of the 'up' input that selects decrementing
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/step_unit.sv
// Combinational +/-1 step and range-end detection for a modulo counter.
// Ports:
//   count_i    : current count value
//   up_i       : direction (DIR_UP increments, DIR_DOWN decrements)
//   mode_i     : MODE_WRAP wraps modulo MODULUS, MODE_SAT holds at the range end
//   next_o     : value the counter takes if it steps this cycle
//   boundary_o : count sits on the range end in the current direction
module step_unit
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             boundary_o
);

  // One extra bit so that MODULUS = 2**WIDTH is representable and the
  // increment of the top value is compared without overflowing.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'sd1);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           at_max;
  logic           at_zero;

  assign count_ext = {1'b0, count_i};
  assign inc_ext   = count_ext + (WIDTH + 1)'(1);
  assign dec_ext   = count_ext - (WIDTH + 1)'(1);

  // Incrementing MODULUS-1 lands exactly on MODULUS.
  assign at_max  = (inc_ext == MOD_EXT);
  // Decrementing zero borrows into the extra bit.
  assign at_zero = dec_ext[WIDTH];

  always_comb begin
    next_o     = count_i;
    boundary_o = 1'b0;
    if (up_i == DIR_UP) begin
      boundary_o = at_max;
      if (!at_max) begin
        next_o = inc_ext[WIDTH-1:0];
      end else if (mode_i == MODE_WRAP) begin
        next_o = '0;
      end
    end else if (up_i == DIR_DOWN) begin
      boundary_o = at_zero;
      if (!at_zero) begin
        next_o = dec_ext[WIDTH-1:0];
      end else if (mode_i == MODE_WRAP) begin
        next_o = MAX_VAL;
      end
    end
  end

endmodule : step_unit

// File: rtl/mod_counter.sv
// Up/down modulo counter with parallel load, wrap or saturate mode.
// Ports:
//   clk      : clock, all state on the rising edge
//   rst      : asynchronous active-high reset (count = 0, carry = 0)
//   en       : count enable
//   load     : synchronous load strobe, has priority over en
//   load_val : value to load, clamped to MODULUS-1
//   up       : 1 = increment, 0 = decrement
//   sat      : 1 = saturate at range ends, 0 = wrap modulo MODULUS
//   count    : registered count
//   tc       : terminal count in the current direction (combinational)
//   carry    : registered pulse on a wrap or a forced saturation hold
module mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'sd1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             carry_q;
  logic             carry_d;
  logic [WIDTH-1:0] step_next;
  logic             at_boundary;
  logic [WIDTH-1:0] load_clamped;

  step_unit #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .count_i    (count_q),
    .up_i       (up),
    .mode_i     (mode_e'(sat)),
    .next_o     (step_next),
    .boundary_o (at_boundary)
  );

  // Out-of-range load values park on the top of the range.
  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      count_d = step_next;
      // A step taken on the range end is either a wrap or a forced hold.
      carry_d = at_boundary;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign tc    = at_boundary;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

  localparam int M10 = 10;
  localparam int M16 = 16;

  typedef struct {
    int cnt;
    bit cy;
    bit tc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en, load, up, sat;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, carry;

  logic       en16, load16, up16, sat16;
  logic [3:0] load_val16;
  logic [3:0] count16;
  logic       tc16, carry16;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  mod_counter #(.WIDTH(4), .MODULUS(M10)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up(up), .sat(sat), .count(count), .tc(tc), .carry(carry)
  );

  mod_counter #(.WIDTH(4), .MODULUS(M16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .load(load16), .load_val(load_val16),
    .up(up16), .sat(sat16), .count(count16), .tc(tc16), .carry(carry16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(int c, bit cy, bit u, int m);
    exp_t e;
    e.cnt = c;
    e.cy  = cy;
    e.tc  = u ? (c == m - 1) : (c == 0);
    return e;
  endfunction

  // Drive one cycle on the modulus-10 counter and queue what it must show.
  task automatic apply(bit e, bit l, int lv, bit u, bit s, int ec, bit ecy);
    en = e; load = l; load_val = 4'(lv); up = u; sat = s;
    exp_q.push_back(mk(ec, ecy, u, M10));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; load = 1'b0; load_val = 4'd0; up = 1'b0; sat = 1'b0;
    en16 = 1'b0; load16 = 1'b0; load_val16 = 4'd0; up16 = 1'b1; sat16 = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b expected 0", carry); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down got %b expected 1", tc); end
    up = 1'b1;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up got %b expected 0", tc); end
    @(posedge clk); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_hold_over_edge got %0d expected 0", count); end
    $display("[reset] count=%0d carry=%b tc=%b", count, carry, tc);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_count_up;
    exp_t e;
    for (int i = 1; i <= 12; i++) begin
      apply(1, 0, 0, 1, 0, i % 10, i == 10);
      e = exp_q.pop_front();
      $display("[count_up] cyc %0d count=%0d carry=%b tc=%b", i, count, carry, tc);
      checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL count_up[%0d] count got %0d expected %0d", i, count, e.cnt); end
      checks++; if (carry !== e.cy) begin errors++; $display("FAIL count_up[%0d] carry got %b expected %b", i, carry, e.cy); end
      checks++; if (tc !== e.tc) begin errors++; $display("FAIL count_up[%0d] tc got %b expected %b", i, tc, e.tc); end
    end
  endtask

  task automatic test_load_down;
    exp_t e;
    int   seq[6] = '{3, 2, 1, 0, 9, 8};
    for (int i = 0; i < 6; i++) begin
      apply(1, i == 0, 3, 0, 0, seq[i], i == 4);
      e = exp_q.pop_front();
      $display("[load_down] cyc %0d count=%0d carry=%b tc=%b", i, count, carry, tc);
      checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL load_down[%0d] count got %0d expected %0d", i, count, e.cnt); end
      checks++; if (carry !== e.cy) begin errors++; $display("FAIL load_down[%0d] carry got %b expected %b", i, carry, e.cy); end
      checks++; if (tc !== e.tc) begin errors++; $display("FAIL load_down[%0d] tc got %b expected %b", i, tc, e.tc); end
    end
  endtask

  task automatic test_load_clamp;
    exp_t e;
    // load 13 -> 9; load over a wrapping enable -> 2; load with en -> 5; then a step down from 5 after a direction change
    int lv[4]  = '{13, 2, 5, 0};
    int ld[4]  = '{1, 1, 1, 0};
    int dir[4] = '{1, 1, 1, 0};
    int ec[4]  = '{9, 2, 5, 4};
    for (int i = 0; i < 4; i++) begin
      apply(1, ld[i] != 0, lv[i], dir[i] != 0, 0, ec[i], 0);
      e = exp_q.pop_front();
      $display("[load_clamp] cyc %0d count=%0d carry=%b tc=%b", i, count, carry, tc);
      checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL load_clamp[%0d] count got %0d expected %0d", i, count, e.cnt); end
      checks++; if (carry !== e.cy) begin errors++; $display("FAIL load_clamp[%0d] carry got %b expected %b", i, carry, e.cy); end
      checks++; if (tc !== e.tc) begin errors++; $display("FAIL load_clamp[%0d] tc got %b expected %b", i, tc, e.tc); end
    end
  endtask

  task automatic test_saturate;
    exp_t e;
    // up: load 8 then 4 enables; down: load 1 then 4 enables; then idle
    int ld[11]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int lv[11]  = '{8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int dir[11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int ena[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int ec[11]  = '{8, 9, 9, 9, 9, 1, 0, 0, 0, 0, 0};
    int ecy[11] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    for (int i = 0; i < 11; i++) begin
      apply(ena[i] != 0, ld[i] != 0, lv[i], dir[i] != 0, 1, ec[i], ecy[i] != 0);
      e = exp_q.pop_front();
      $display("[saturate] cyc %0d count=%0d carry=%b tc=%b", i, count, carry, tc);
      checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL saturate[%0d] count got %0d expected %0d", i, count, e.cnt); end
      checks++; if (carry !== e.cy) begin errors++; $display("FAIL saturate[%0d] carry got %b expected %b", i, carry, e.cy); end
      checks++; if (tc !== e.tc) begin errors++; $display("FAIL saturate[%0d] tc got %b expected %b", i, tc, e.tc); end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    // load 9, wrap to 0 with carry high
    apply(0, 1, 9, 1, 0, 9, 0);
    e = exp_q.pop_front();
    checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL arst_load9 count got %0d expected %0d", count, e.cnt); end
    apply(1, 0, 0, 1, 0, 0, 1);
    e = exp_q.pop_front();
    checks++; if (carry !== e.cy) begin errors++; $display("FAIL arst_wrap carry got %b expected %b", carry, e.cy); end
    #3 rst = 1'b1;
    #1;
    $display("[async_reset] carry clear count=%0d carry=%b", count, carry);
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL arst_carry_immediate got %b expected 0", carry); end
    @(negedge clk);
    rst = 1'b0;
    apply(0, 1, 6, 1, 0, 6, 0);
    e = exp_q.pop_front();
    checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL arst_load6 count got %0d expected %0d", count, e.cnt); end
    // mid-cycle reset with a load and an enable pending
    load = 1'b1; load_val = 4'd2; en = 1'b1;
    #3 rst = 1'b1;
    #1;
    $display("[async_reset] mid-cycle count=%0d carry=%b", count, carry);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_count_immediate got %0d expected 0", count); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL arst_carry_mid got %b expected 0", carry); end
    @(posedge clk); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_discard_load got %0d expected 0", count); end
    @(negedge clk);
    rst = 1'b0;
    apply(1, 0, 0, 1, 0, 1, 0);
    e = exp_q.pop_front();
    $display("[async_reset] release count=%0d carry=%b tc=%b", count, carry, tc);
    checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL arst_release count got %0d expected %0d", count, e.cnt); end
    checks++; if (carry !== e.cy) begin errors++; $display("FAIL arst_release carry got %b expected %b", carry, e.cy); end
  endtask

  task automatic test_random;
    exp_t e;
    int   mc;
    bit   re, rl, ru, rs, ecy;
    int   rlv;
    apply(0, 1, 0, 1, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL random_init count got %0d expected %0d", count, e.cnt); end
    mc = 0;
    for (int i = 0; i < 120; i++) begin
      re  = ($urandom_range(0, 3) != 0);
      rl  = ($urandom_range(0, 7) == 0);
      ru  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      rlv = $urandom_range(0, 15);
      ecy = 1'b0;
      if (rl) begin
        mc = (rlv >= M10) ? M10 - 1 : rlv;
      end else if (re) begin
        if (ru && mc == M10 - 1) begin
          ecy = 1'b1;
          if (!rs) mc = 0;
        end else if (!ru && mc == 0) begin
          ecy = 1'b1;
          if (!rs) mc = M10 - 1;
        end else begin
          mc = ru ? mc + 1 : mc - 1;
        end
      end
      apply(re, rl, rlv, ru, rs, mc, ecy);
      e = exp_q.pop_front();
      $display("[random] cyc %0d en=%b ld=%b lv=%0d up=%b sat=%b count=%0d carry=%b tc=%b",
               i, re, rl, rlv, ru, rs, count, carry, tc);
      checks++; if (count !== 4'(e.cnt)) begin errors++; $display("FAIL random[%0d] count got %0d expected %0d", i, count, e.cnt); end
      checks++; if (carry !== e.cy) begin errors++; $display("FAIL random[%0d] carry got %b expected %b", i, carry, e.cy); end
      checks++; if (tc !== e.tc) begin errors++; $display("FAIL random[%0d] tc got %b expected %b", i, tc, e.tc); end
    end
    en = 1'b0; load = 1'b0;
  endtask

  task automatic test_full_range;
    exp_t e;
    // load 15, wrap up to 0, wrap down to 15, saturate at 15
    int ld[4]  = '{1, 0, 0, 0};
    int dir[4] = '{1, 1, 0, 1};
    int st[4]  = '{0, 0, 0, 1};
    int ec[4]  = '{15, 0, 15, 15};
    int ecy[4] = '{0, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      en16 = 1'b1; load16 = (ld[i] != 0); load_val16 = 4'd15; up16 = (dir[i] != 0); sat16 = (st[i] != 0);
      exp_q.push_back(mk(ec[i], ecy[i] != 0, dir[i] != 0, M16));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      $display("[full_range] cyc %0d count=%0d carry=%b tc=%b", i, count16, carry16, tc16);
      checks++; if (count16 !== 4'(e.cnt)) begin errors++; $display("FAIL full_range[%0d] count got %0d expected %0d", i, count16, e.cnt); end
      checks++; if (carry16 !== e.cy) begin errors++; $display("FAIL full_range[%0d] carry got %b expected %b", i, carry16, e.cy); end
      checks++; if (tc16 !== e.tc) begin errors++; $display("FAIL full_range[%0d] tc got %b expected %b", i, tc16, e.tc); end
    end
    en16 = 1'b0; load16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_down();
    test_load_clamp();
    test_saturate();
    test_async_reset();
    test_random();
    test_full_range();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mod_counter

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter bit width (2..32).
REQ-002 The block SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port en  input  1  count enable.
REQ-006 The block SHALL have port load  input  1  synchronous parallel load strobe.
REQ-007 The block SHALL have port load_val  input  WIDTH  value to load.
REQ-008 The block SHALL have port up  input  1  direction, 1 = increment, 0 = decrement.
REQ-009 The block SHALL have port sat  input  1  mode, 1 = saturate at range ends, 0 = wrap modulo MODULUS.
REQ-010 The block SHALL have port count  output  WIDTH  current count, registered.
REQ-011 The block SHALL have port tc  output  1  terminal count, combinational.
REQ-012 The block SHALL have port carry  output  1  one-cycle registered pulse on wrap or saturation hit.

Function
REQ-013 Per-cycle priority SHALL be: rst > load > en > hold.
REQ-014 On load, count SHALL take load_val next edge; if load_val >= MODULUS it SHALL take MODULUS-1; carry SHALL be 0 that cycle.
REQ-015 With en=1, up=1, count < MODULUS-1: count SHALL become count+1 next edge, carry 0.
REQ-016 With en=1, up=0, count > 0: count SHALL become count-1 next edge, carry 0.
REQ-017 Wrap mode (sat=0), en=1, up=1, count = MODULUS-1: count SHALL become 0 and carry SHALL be 1 for exactly one cycle.
REQ-018 Wrap mode, en=1, up=0, count = 0: count SHALL become MODULUS-1 and carry SHALL be 1 for one cycle.
REQ-019 Saturate mode (sat=1) at the boundary in the counting direction: count SHALL hold and carry SHALL be 1 for every cycle the hold is forced by en=1.
REQ-020 tc SHALL be 1 when (up=1 and count = MODULUS-1) or (up=0 and count = 0), independent of en and sat.
REQ-021 With en=0 and load=0, count SHALL hold and carry SHALL be 0.
REQ-022 Changing up or sat mid-count SHALL take effect on the very next edge, no pipeline delay.
REQ-023 Latency from en/load to count change SHALL be exactly one clock.
REQ-024 Internal next-value arithmetic SHALL be WIDTH+1 bits so MODULUS = 2**WIDTH never overflows silently.

Reset
REQ-025 rst assertion SHALL immediately drive count = 0 and carry = 0, without waiting for clk.
REQ-026 rst asserted mid-count SHALL discard any pending load or enable; the first edge after release SHALL act normally on inputs.
REQ-027 tc SHALL read 1 during reset when up=0, 0 when up=1 (MODULUS > 1).

Structure
REQ-028 A shared package counter_pkg SHALL hold the mode enum (MODE_WRAP, MODE_SAT) and the direction constants DIR_UP, DIR_DOWN.
REQ-029 The +/-1 next-value and boundary-detect logic SHALL sit in one combinational sub-module step_unit (parameters WIDTH, MODULUS; outputs next value, boundary flag); mod_counter SHALL hold only the registers and priority muxing.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-030 Reset then en=1, up=1, sat=0 for 12 cycles -> count 1..9, 0, 1, 2; carry high only on the 9->0 cycle; tc high while count=9.
REQ-031 load=1, load_val=3, up=0, sat=0, en=1 for 5 cycles -> count 3, 2, 1, 0, 9, 8; carry pulse on 0->9.
REQ-032 load_val=13 with load=1 -> count=9 (clamped), carry=0; load=1 and en=1 together -> load wins.
REQ-033 sat=1, up=1 from count=8, en=1 for 4 cycles -> 9, 9, 9, 9; carry 0 then 1, 1, 1; same downward at 0.
REQ-034 Assert rst between edges while count=6 -> count=0 and carry=0 immediately; release, en=1 -> count=1 next edge.
REQ-035 WIDTH=4, MODULUS=16, up=1, sat=0 from 15 -> count 0, carry=1 (full-range wrap, no width overflow).
